// File: rtl/zbb_count_seq.sv
// ============================================================================
// Module   : zbb_count_seq
// Function : Zbb clz/ctz/cpop sequencer driving a shared leading-zero encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zbb_count_seq #(
  parameter int XLEN     = 32,
  parameter int POP_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] enc_in_o,
  input  logic [5:0]      enc_cnt_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            err_o
);

  localparam int         POP_ITERS = XLEN / POP_STEP;
  localparam int         CW        = $clog2(POP_ITERS);
  localparam logic [5:0] MAX_CNT   = 6'(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_POP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] enc_in_q;
  logic [XLEN-1:0] shift_q;
  logic [XLEN-1:0] result_q;
  logic [5:0]      acc_q;
  logic [CW-1:0]   iter_q;
  logic            err_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [XLEN-1:0] rev_d;
  logic [5:0]      nib_cnt_d;
  logic [5:0]      acc_d;

  // ctz is computed as clz of the bit-reversed operand
  generate
    for (genvar i = 0; i < XLEN; i++) begin : g_rev
      assign rev_d[i] = rs1_i[XLEN-1-i];
    end
  endgenerate

  always_comb begin
    nib_cnt_d = '0;
    for (int b = 0; b < POP_STEP; b++) begin
      nib_cnt_d = nib_cnt_d + 6'(shift_q[b]);
    end
    acc_d = acc_q + nib_cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      enc_in_q    <= '0;
      shift_q     <= '0;
      result_q    <= '0;
      acc_q       <= '0;
      iter_q      <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            in_ready_q <= 1'b0;
            case (op_i)
              2'b00: begin
                enc_in_q <= rs1_i;
                state_q  <= S_ENC;
              end
              2'b01: begin
                enc_in_q <= rev_d;
                state_q  <= S_ENC;
              end
              2'b10: begin
                shift_q <= rs1_i;
                acc_q   <= '0;
                iter_q  <= '0;
                state_q <= S_POP;
              end
              default: begin
                result_q    <= '0;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
            endcase
          end
        end
        S_ENC: begin
          // An out-of-range encoder count saturates and is flagged sticky
          if (enc_cnt_i > MAX_CNT) begin
            result_q <= {{(XLEN-6){1'b0}}, MAX_CNT};
            err_q    <= 1'b1;
          end else begin
            result_q <= {{(XLEN-6){1'b0}}, enc_cnt_i};
          end
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_POP: begin
          acc_q   <= acc_d;
          shift_q <= shift_q >> POP_STEP;
          iter_q  <= iter_q + CW'(1);
          if (iter_q == CW'(POP_ITERS - 1)) begin
            result_q    <= {{(XLEN-6){1'b0}}, acc_d};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign enc_in_o    = enc_in_q;
  assign result_o    = result_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_zbb_count_seq.sv
// ============================================================================
// Module   : tb_zbb_count_seq
// Function : Self-checking bench for zbb_count_seq with a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_zbb_count_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic        flush;
  logic [31:0] enc_in;
  logic [5:0]  enc_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err;

  logic        ovr_en  = 1'b0;
  logic [5:0]  ovr_val = 6'd0;

  int vec = 0;
  int mis = 0;

  always #5 clk = ~clk;

  function automatic int lz32(input logic [31:0] x);
    int n = 32;
    for (int i = 0; i < 32; i++) if (x[i]) n = 31 - i;
    return n;
  endfunction

  function automatic int tz32(input logic [31:0] x);
    int n = 32;
    for (int i = 31; i >= 0; i--) if (x[i]) n = i;
    return n;
  endfunction

  function automatic int pop32(input logic [31:0] x);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(x[i]);
    return n;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Shared leading-zero encoder, with an injectable faulty count
  assign enc_cnt = ovr_en ? ovr_val : 6'(lz32(enc_in));

  zbb_count_seq #(.XLEN(32), .POP_STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_i       (op),
    .rs1_i      (rs1),
    .flush_i    (flush),
    .enc_in_o   (enc_in),
    .enc_cnt_i  (enc_cnt),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .err_o      (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request is busy for a fixed latency and then
  // presents its arithmetically computed count until retired.
  logic        m_busy, m_valid, m_err, m_err_pend;
  logic [31:0] m_result, m_enc;
  int          m_wait;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0; m_err_pend <= 1'b0;
      m_result <= '0; m_enc <= '0; m_wait <= 0;
    end else if (flush) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy     <= 1'b1;
        m_err_pend <= 1'b0;
        case (op)
          2'b00, 2'b01: begin
            m_enc  <= (op == 2'b00) ? rs1 : rev32(rs1);
            m_wait <= 1;
            if (ovr_en) begin
              m_result   <= (ovr_val > 6'd32) ? 32'd32 : 32'(ovr_val);
              m_err_pend <= (ovr_val > 6'd32);
            end else begin
              m_result <= (op == 2'b00) ? 32'(lz32(rs1)) : 32'(tz32(rs1));
            end
          end
          2'b10: begin m_result <= 32'(pop32(rs1)); m_wait <= 8; end
          default: begin m_result <= '0; m_wait <= 0; m_valid <= 1'b1; end
        endcase
      end
    end else if (!m_valid) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid <= 1'b1;
        if (m_err_pend) m_err <= 1'b1;
      end
    end else if (out_ready) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("err", 32'(err), 32'(m_err));
      check("enc_in", enc_in, m_enc);
      if (m_valid) check("result", result, m_result);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] v,
                       input int exp_res, input int exp_lat,
                       input bit chk_enc, input logic [31:0] exp_enc);
    int n = 0;
    @(posedge clk); #1;
    wait_idle();
    in_valid = 1'b1; op = o; rs1 = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (chk_enc && n == 1) check({name, "_enc_in"}, enc_in, exp_enc);
      if (out_valid) break;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_result"}, result, 32'(exp_res));
  endtask

  initial begin
    int acc[$];
    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; rs1 = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_enc_in", enc_in, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    #10 rst_n = 1'b1;

    do_op("clz_bit16", 2'b00, 32'h0001_0000, 15, 2, 1'b1, 32'h0001_0000);
    do_op("clz_zero",  2'b00, 32'h0000_0000, 32, 2, 1'b0, '0);
    do_op("clz_msb",   2'b00, 32'h8000_0000,  0, 2, 1'b0, '0);
    do_op("ctz_bit16", 2'b01, 32'h0001_0000, 16, 2, 1'b1, 32'h0000_8000);
    do_op("ctz_zero",  2'b01, 32'h0000_0000, 32, 2, 1'b0, '0);
    do_op("cpop_mix",  2'b10, 32'hF0F0_0001,  9, 9, 1'b0, '0);
    do_op("cpop_ones", 2'b10, 32'hFFFF_FFFF, 32, 9, 1'b0, '0);
    do_op("cpop_zero", 2'b10, 32'h0000_0000,  0, 9, 1'b0, '0);
    do_op("reserved",  2'b11, 32'h1234_5678,  0, 1, 1'b0, '0);

    // Backpressure then retire
    @(posedge clk); #1;
    wait_idle();
    out_ready = 1'b0;
    do_op("bp_clz", 2'b00, 32'h0001_0000, 15, 2, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", result, 32'd15);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("retire_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back clz requests held valid
    in_valid = 1'b1; op = 2'b00; rs1 = 32'h00F0_0000;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (in_ready) acc.push_back(c);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    check("b2b_count", 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      check("b2b_gap1", 32'(acc[1] - acc[0]), 32'd3);
      check("b2b_gap2", 32'(acc[2] - acc[1]), 32'd3);
    end

    // Flush on the 4th POP cycle
    wait_idle();
    in_valid = 1'b1; op = 2'b10; rs1 = 32'hFFFF_0000;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) check("flush_no_valid", 32'(out_valid), 32'd0);
    end
    do_op("post_flush_clz", 2'b00, 32'h0000_00FF, 24, 2, 1'b0, '0);

    // Faulty encoder count saturates and sets the sticky error
    ovr_en = 1'b1; ovr_val = 6'd40;
    do_op("enc_over", 2'b00, 32'h0000_0001, 32, 2, 1'b0, '0);
    ovr_en = 1'b0;
    @(negedge clk);
    check("err_set", 32'(err), 32'd1);
    do_op("err_cpop", 2'b10, 32'h0000_0007, 3, 9, 1'b0, '0);
    check("err_sticky", 32'(err), 32'd1);

    // Asynchronous reset mid-POP
    @(posedge clk); #1;
    wait_idle();
    in_valid = 1'b1; op = 2'b10; rs1 = 32'hFFFF_FFFF;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_enc_in", enc_in, 32'd0);
    check("arst_err", 32'(err), 32'd0);
    #3 rst_n = 1'b1;
    do_op("post_rst_ctz", 2'b01, 32'h0000_0100, 8, 2, 1'b1, 32'h0080_0000);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
